// File: rtl/rpn_pilha_ctrl.sv
// RPN operand stack and sequencer in front of the combinational 8-bit ALU.
// Pops operands into registered ALU inputs, then writes the ALU result back.
//
// state | meaning
// IDLE  | accepts push/op commands
// EXEC  | ALU settles on the registered operands
// WB    | capture flags, write result back (or keep operands on erro)
module rpn_pilha_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          op,
  input  logic [2:0]    sel,
  input  logic          cin,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_sel,
  output logic          alu_cin,
  input  logic [7:0]    alu_s,
  input  logic [4:0]    alu_flags,
  output logic [7:0]    top,
  output logic [PW-1:0] depth,
  output logic [4:0]    flags_q,
  output logic          busy,
  output logic          err_under,
  output logic          err_over,
  output logic          err_div,
  output logic          cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [2:0]    SEL_NOT = 3'b111;

  state_t          state_q, state_d;
  logic [7:0]      stack_q [DEPTH];
  logic [7:0]      stack_d [DEPTH];
  logic [PW-1:0]   depth_q, depth_d;
  logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic            alu_cin_q, alu_cin_d;
  logic [4:0]      flags_d;
  logic            err_under_q, err_under_d, err_over_q, err_over_d;
  logic            err_div_q, err_div_d, cmd_err_q, cmd_err_d;
  logic [PW-1:0]   top_idx, below_idx;
  logic [7:0]      top_val, below_val;
  logic            has_ops;

  assign top_idx   = depth_q - PW'(1);
  assign below_idx = depth_q - PW'(2);
  assign has_ops   = (sel == SEL_NOT) ? (depth_q != '0) : (depth_q >= PW'(2));

  always_comb begin
    top_val   = '0;
    below_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q != '0 && PW'(i) == top_idx) top_val = stack_q[i];
      if (depth_q >= PW'(2) && PW'(i) == below_idx) below_val = stack_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      depth_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_cin_q   <= 1'b0;
      flags_q     <= '0;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
      err_div_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
      depth_q     <= depth_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_cin_q   <= alu_cin_d;
      flags_q     <= flags_d;
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
      err_div_q   <= err_div_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (op && !push && has_ops) state_d = S_EXEC;
        S_EXEC:  state_d = S_WB;
        S_WB:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];
    depth_d     = depth_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    alu_cin_d   = alu_cin_q;
    flags_d     = flags_q;
    err_under_d = err_under_q;
    err_over_d  = err_over_q;
    err_div_d   = err_div_q;
    cmd_err_d   = 1'b0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stack_d[i] = '0;
      depth_d     = '0;
      alu_a_d     = '0;
      alu_b_d     = '0;
      alu_sel_d   = '0;
      alu_cin_d   = 1'b0;
      flags_d     = '0;
      err_under_d = 1'b0;
      err_over_d  = 1'b0;
      err_div_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (push && op) begin
            cmd_err_d = 1'b1;
          end else if (push) begin
            if (depth_q < DEPTH_C) begin
              for (int i = 0; i < DEPTH; i++)
                if (PW'(i) == depth_q) stack_d[i] = din;
              depth_d = depth_q + PW'(1);
            end else begin
              err_over_d = 1'b1;
            end
          end else if (op) begin
            if (!has_ops) begin
              err_under_d = 1'b1;
            end else begin
              alu_sel_d = sel;
              alu_cin_d = cin;
              if (sel == SEL_NOT) begin
                alu_a_d = top_val;
                alu_b_d = '0;
              end else begin
                alu_a_d = below_val;
                alu_b_d = top_val;
              end
            end
          end
        end
        S_EXEC: begin
          cmd_err_d = push | op;
        end
        S_WB: begin
          cmd_err_d = push | op;
          flags_d   = alu_flags;
          // erro leaves the operands on the stack so the user can retry
          if (alu_flags[3]) begin
            err_div_d = 1'b1;
          end else if (alu_sel_q == SEL_NOT) begin
            for (int i = 0; i < DEPTH; i++)
              if (PW'(i) == top_idx) stack_d[i] = alu_s;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (PW'(i) == below_idx) stack_d[i] = alu_s;
              if (PW'(i) == top_idx) stack_d[i] = '0;
            end
            depth_d = depth_q - PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_cin   = alu_cin_q;
  assign top       = top_val;
  assign depth     = depth_q;
  assign busy      = (state_q != S_IDLE);
  assign err_under = err_under_q;
  assign err_over  = err_over_q;
  assign err_div   = err_div_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_rpn_pilha_ctrl.sv
// Bench for rpn_pilha_ctrl: a behavioural ALU, a directed vector table,
// an async-reset corner case and random commands against a queue model.
module tb_rpn_pilha_ctrl;

  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear = 1'b0, push = 1'b0, op = 1'b0, cin = 1'b0;
  logic [7:0]    din = '0;
  logic [2:0]    sel = '0;
  logic [7:0]    alu_a, alu_b, alu_s, top;
  logic [2:0]    alu_sel;
  logic          alu_cin, busy, err_under, err_over, err_div, cmd_err;
  logic [4:0]    alu_flags, flags_q;
  logic [PW-1:0] depth;

  int n_tests = 0;
  int n_fail  = 0;

  rpn_pilha_ctrl #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .din(din),
    .op(op), .sel(sel), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_s(alu_s), .alu_flags(alu_flags),
    .top(top), .depth(depth), .flags_q(flags_q), .busy(busy),
    .err_under(err_under), .err_over(err_over), .err_div(err_div),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // ALU: returns {flags{resto,erro,zero,overflow,cout}, s}
  function automatic logic [12:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s, input logic c);
    logic [8:0]  w;
    logic [15:0] p;
    logic [7:0]  r;
    logic [4:0]  f;
    f = '0;
    r = '0;
    w = '0;
    p = '0;
    case (s)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b} + 9'(c);
        r = w[7:0]; f[0] = w[8];
        f[1] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        w = {1'b0, a} - {1'b0, b} - 9'(c);
        r = w[7:0]; f[0] = w[8];
        f[1] = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: begin
        p = 16'(a) * 16'(b);
        r = p[7:0]; f[0] = |p[15:8];
      end
      3'd3: begin
        if (b == 8'd0) f[3] = 1'b1;
        else begin
          r = a / b; f[4] = ((a % b) != 8'd0);
        end
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~a;
    endcase
    f[2] = (r == 8'd0);
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_s} = alu_f(alu_a, alu_b, alu_sel, alu_cin);

  function automatic logic [40:0] pk(input logic [7:0] t, input logic [2:0] d,
                                     input logic [4:0] f, input logic [2:0] e,
                                     input logic cm, input logic bz,
                                     input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] s, input logic c);
    return {t, d, f, e, cm, bz, a, b, s, c};
  endfunction

  function automatic logic [40:0] dut_snap();
    return pk(top, depth, flags_q, {err_under, err_over, err_div}, cmd_err, busy,
              alu_a, alu_b, alu_sel, alu_cin);
  endfunction

  task automatic chk(input string nm, input logic [40:0] act, input logic [40:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic p, input logic o,
                     input logic [7:0] d, input logic [2:0] s, input logic ci);
    @(negedge clk);
    clear = c; push = p; op = o; din = d; sel = s; cin = ci;
    @(posedge clk);
    #1;
    clear = 1'b0; push = 1'b0; op = 1'b0;
  endtask

  typedef struct {
    logic        c, p, o;
    logic [7:0]  d;
    logic [2:0]  s;
    logic        ci;
    logic [40:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic c, input logic p, input logic o, input logic [7:0] d,
                     input logic [2:0] s, input logic ci, input logic [40:0] exp);
    vec_t v;
    v.c = c; v.p = p; v.o = o; v.d = d; v.s = s; v.ci = ci; v.exp = exp;
    vq.push_back(v);
  endtask

  // reference model state
  logic [7:0] stk[$];
  logic [4:0] m_flags;
  logic       m_under, m_over, m_div, m_cmd;
  logic [7:0] m_a, m_b;
  logic [2:0] m_sel;
  logic       m_cin;

  task automatic model_reset();
    stk.delete();
    m_flags = '0; m_under = 0; m_over = 0; m_div = 0; m_cmd = 0;
    m_a = '0; m_b = '0; m_sel = '0; m_cin = 0;
  endtask

  function automatic logic [40:0] model_snap();
    logic [7:0] t;
    t = (stk.size() == 0) ? 8'h00 : stk[stk.size()-1];
    return pk(t, 3'(stk.size()), m_flags, {m_under, m_over, m_div}, m_cmd, 1'b0,
              m_a, m_b, m_sel, m_cin);
  endfunction

  initial begin
    logic [7:0]  d;
    logic [2:0]  s;
    logic        c, inj, pi, oi;
    logic [12:0] res;
    logic [7:0]  opa, opb;
    int          k, need;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", dut_snap(), '0);
    rst_n = 1'b1;

    add(0,1,0,8'h12,0,0, pk(8'h12,1,5'h00,3'b000,0,0,8'h00,8'h00,0,0));
    add(0,1,0,8'h34,0,0, pk(8'h34,2,5'h00,3'b000,0,0,8'h00,8'h00,0,0));
    add(0,0,1,8'h00,0,0, pk(8'h34,2,5'h00,3'b000,0,1,8'h12,8'h34,0,0));
    add(0,0,0,8'h00,0,0, pk(8'h34,2,5'h00,3'b000,0,1,8'h12,8'h34,0,0));
    add(0,0,0,8'h00,0,0, pk(8'h46,1,5'h00,3'b000,0,0,8'h12,8'h34,0,0));
    add(0,1,0,8'hFF,0,0, pk(8'hFF,2,5'h00,3'b000,0,0,8'h12,8'h34,0,0));
    add(0,1,0,8'h01,0,0, pk(8'h01,3,5'h00,3'b000,0,0,8'h12,8'h34,0,0));
    add(0,0,1,8'h00,0,0, pk(8'h01,3,5'h00,3'b000,0,1,8'hFF,8'h01,0,0));
    add(0,0,0,8'h00,0,0, pk(8'h01,3,5'h00,3'b000,0,1,8'hFF,8'h01,0,0));
    add(0,0,0,8'h00,0,0, pk(8'h00,2,5'h05,3'b000,0,0,8'hFF,8'h01,0,0));
    add(0,1,0,8'hAA,0,0, pk(8'hAA,3,5'h05,3'b000,0,0,8'hFF,8'h01,0,0));
    add(0,1,0,8'hBB,0,0, pk(8'hBB,4,5'h05,3'b000,0,0,8'hFF,8'h01,0,0));
    add(0,1,0,8'hCC,0,0, pk(8'hBB,4,5'h05,3'b010,0,0,8'hFF,8'h01,0,0));
    add(0,0,1,8'h00,7,0, pk(8'hBB,4,5'h05,3'b010,0,1,8'hBB,8'h00,7,0));
    add(0,0,0,8'h00,0,0, pk(8'hBB,4,5'h05,3'b010,0,1,8'hBB,8'h00,7,0));
    add(0,0,0,8'h00,0,0, pk(8'h44,4,5'h00,3'b010,0,0,8'hBB,8'h00,7,0));
    add(0,0,1,8'h00,1,1, pk(8'h44,4,5'h00,3'b010,0,1,8'hAA,8'h44,1,1));
    add(0,0,0,8'h00,0,0, pk(8'h44,4,5'h00,3'b010,0,1,8'hAA,8'h44,1,1));
    add(0,0,0,8'h00,0,0, pk(8'h65,3,5'h02,3'b010,0,0,8'hAA,8'h44,1,1));
    add(0,0,1,8'h00,3,0, pk(8'h65,3,5'h02,3'b010,0,1,8'h00,8'h65,3,0));
    add(0,0,0,8'h00,0,0, pk(8'h65,3,5'h02,3'b010,0,1,8'h00,8'h65,3,0));
    add(0,0,0,8'h00,0,0, pk(8'h00,2,5'h04,3'b010,0,0,8'h00,8'h65,3,0));
    add(0,0,1,8'h00,3,0, pk(8'h00,2,5'h04,3'b010,0,1,8'h46,8'h00,3,0));
    add(0,0,0,8'h00,0,0, pk(8'h00,2,5'h04,3'b010,0,1,8'h46,8'h00,3,0));
    add(0,0,0,8'h00,0,0, pk(8'h00,2,5'h0C,3'b011,0,0,8'h46,8'h00,3,0));
    add(0,1,0,8'h07,0,0, pk(8'h07,3,5'h0C,3'b011,0,0,8'h46,8'h00,3,0));
    add(0,0,1,8'h00,2,0, pk(8'h07,3,5'h0C,3'b011,0,1,8'h00,8'h07,2,0));
    add(0,1,0,8'h99,0,0, pk(8'h07,3,5'h0C,3'b011,1,1,8'h00,8'h07,2,0));
    add(0,0,0,8'h00,0,0, pk(8'h00,2,5'h04,3'b011,0,0,8'h00,8'h07,2,0));
    add(0,1,1,8'h55,0,0, pk(8'h00,2,5'h04,3'b011,1,0,8'h00,8'h07,2,0));
    add(1,0,0,8'h00,0,0, pk(8'h00,0,5'h00,3'b000,0,0,8'h00,8'h00,0,0));
    add(0,0,1,8'h00,1,0, pk(8'h00,0,5'h00,3'b100,0,0,8'h00,8'h00,0,0));
    add(0,1,0,8'h0F,0,0, pk(8'h0F,1,5'h00,3'b100,0,0,8'h00,8'h00,0,0));
    add(0,0,1,8'h00,7,0, pk(8'h0F,1,5'h00,3'b100,0,1,8'h0F,8'h00,7,0));
    add(0,0,0,8'h00,0,0, pk(8'h0F,1,5'h00,3'b100,0,1,8'h0F,8'h00,7,0));
    add(0,0,0,8'h00,0,0, pk(8'hF0,1,5'h00,3'b100,0,0,8'h0F,8'h00,7,0));
    add(1,0,0,8'h00,0,0, pk(8'h00,0,5'h00,3'b000,0,0,8'h00,8'h00,0,0));
    add(0,1,0,8'h21,0,0, pk(8'h21,1,5'h00,3'b000,0,0,8'h00,8'h00,0,0));
    add(0,0,1,8'h00,0,0, pk(8'h21,1,5'h00,3'b100,0,0,8'h00,8'h00,0,0));
    add(1,1,0,8'h77,0,0, pk(8'h00,0,5'h00,3'b000,0,0,8'h00,8'h00,0,0));

    foreach (vq[i]) begin
      cyc(vq[i].c, vq[i].p, vq[i].o, vq[i].d, vq[i].s, vq[i].ci);
      chk($sformatf("vec%0d", i), dut_snap(), vq[i].exp);
    end

    // async reset in the middle of EXEC
    cyc(0,1,0,8'h11,0,0);
    cyc(0,1,0,8'h22,0,0);
    cyc(0,0,1,8'h00,0,1);
    chk("exec_busy", {40'd0, busy}, 41'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_exec", dut_snap(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0,1,0,8'h5A,0,0);
    chk("push_after_rst", dut_snap(), pk(8'h5A,1,5'h00,3'b000,0,0,8'h00,8'h00,0,0));

    // random commands against the queue model
    cyc(1,0,0,8'h00,0,0);
    model_reset();
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 99);
      d = 8'($urandom);
      s = 3'($urandom_range(0, 7));
      c = 1'($urandom_range(0, 1));
      m_cmd = 1'b0;
      if (k < 40) begin
        cyc(0,1,0,d,s,c);
        if (stk.size() < DEPTH) stk.push_back(d);
        else m_over = 1'b1;
      end else if (k < 80) begin
        cyc(0,0,1,d,s,c);
        need = (s == 3'd7) ? 1 : 2;
        if (stk.size() < need) begin
          m_under = 1'b1;
        end else begin
          chk("rand_busy", {40'd0, busy}, 41'd1);
          if (s == 3'd7) begin
            opa = stk[stk.size()-1]; opb = 8'h00;
          end else begin
            opa = stk[stk.size()-2]; opb = stk[stk.size()-1];
          end
          m_a = opa; m_b = opb; m_sel = s; m_cin = c;
          for (int j = 0; j < 2; j++) begin
            inj = ($urandom_range(0, 2) == 0);
            pi = inj & 1'($urandom_range(0, 1));
            oi = inj & ~pi;
            cyc(0, pi, oi, 8'($urandom), 3'($urandom_range(0, 7)), 1'b0);
            if (j == 0) chk("rand_busy_cmd_err", {40'd0, cmd_err}, {40'd0, inj});
            else m_cmd = inj;
          end
          res = alu_f(opa, opb, s, c);
          m_flags = res[12:8];
          if (res[11]) begin
            m_div = 1'b1;
          end else if (s == 3'd7) begin
            stk[stk.size()-1] = res[7:0];
          end else begin
            void'(stk.pop_back());
            void'(stk.pop_back());
            stk.push_back(res[7:0]);
          end
        end
      end else if (k < 85) begin
        cyc(0,1,1,d,s,c);
        m_cmd = 1'b1;
      end else if (k < 89) begin
        cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, s, c);
        model_reset();
      end else begin
        cyc(0,0,0,d,s,c);
      end
      chk($sformatf("rand%0d", it), dut_snap(), model_snap());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
